pxs_str_vga_split: RTL and testbench
====================================

PXS_STR_VGA_SPLIT -- requirements
Module: pxs_str_vga_split

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 VGAStr  input  23  VGA stream; field positions per Pxs.vh macros HS, VS, Active, XC[9:0], YC[9:0].
REQ-006 err_clr  input  1  clears err.
REQ-007 HSync, VSync, ActiveVideo  output  1 each  registered stream fields.
REQ-008 XCoord, YCoord  output  10 each  registered scan coordinates.
REQ-009 sol, eol, sof, eof  output  1 each  start/end of active line/frame, one-cycle pulses.
REQ-010 locked  output  1  stream synchronised.
REQ-011 frame_cnt  output  16  completed frames while locked.
REQ-012 err  output  1  sticky coordinate-continuity error.

Function
REQ-013 All outputs registered; latency exactly 1 clk from VGAStr to every output; no combinational in-to-out path.
REQ-014 Field outputs equal the corresponding VGAStr fields sampled the previous cycle.
REQ-015 sol = Active & XC==0; eol = Active & XC==H_ACTIVE-1; sof = sol & YC==0; eof = eol & YC==V_ACTIVE-1; evaluated on sampled input, asserted with the registered pixel.
REQ-016 Internal history: prev_act, prev_x, prev_y, last_line_y (Y of last eol), after_eof flag.
REQ-017 FSM states UNLOCKED, LOCKED; reset state UNLOCKED.
REQ-018 UNLOCKED -> LOCKED on sampled sof; locked output rises with that sof pulse.
REQ-019 LOCKED -> UNLOCKED on continuity error (REQ-020); no other exit except reset.
REQ-020 Continuity error when LOCKED and Active: prev_act & (XC!=prev_x+1 | YC!=prev_y); or !prev_act & XC!=0; or !prev_act & YC!=(after_eof ? 0 : last_line_y+1). Inactive cycles never error.
REQ-021 Coordinate comparisons in 10-bit arithmetic; X==H_ACTIVE-1 followed by Active next cycle is an error (no implicit wrap).
REQ-022 err set on continuity error, held until err_clr; simultaneous err_clr and new error -> err=1 (set wins).
REQ-023 The sof that relocks after an error is itself not checked.
REQ-024 frame_cnt increments on eof only in LOCKED; wraps 65535 -> 0.
REQ-025 HSync/VSync pass through unchecked; polarity irrelevant to block.

Reset
REQ-026 On rst_n=0 at clk edge: all outputs 0, XCoord=YCoord=0, frame_cnt=0, err=0, state UNLOCKED, history cleared (after_eof=1).
REQ-027 Reset mid-frame: block relocks only at next sof; partial frame not counted.

Configuration
REQ-028 Macro PXS_VGA_SPLIT_CHECK_EN: defined -> REQ-020/022/023 checker compiled in.
REQ-029 Undefined -> no checker logic; err tied 0, err_clr ignored, LOCKED never exits except reset; all other behaviour identical.

Verification
REQ-030 Reset then 640x480 raster, 3 frames -> locked rises at first sof, frame_cnt=3, err=0, outputs lag input by 1 clk.
REQ-031 Line 10, X jumps 99->101 (CHECK_EN) -> err=1 and locked=0 on pixel 101 output cycle; relock at next sof, frame_cnt unchanged for faulty frame.
REQ-032 err_clr asserted same cycle as new error -> err remains 1; err_clr alone later -> err=0 next cycle.
REQ-033 frame_cnt preloaded to 65535 via 65535 frames (or forced) then one eof -> frame_cnt=0.
REQ-034 rst_n low at X=320,Y=200 -> all outputs 0 next cycle; locked=0 until next Y=0,X=0 active pixel.
REQ-035 Same as REQ-031 with macro undefined -> err=0, locked stays 1.

Source files
------------

// File: rtl/pxs_str_vga_split.sv
// VGA stream splitter: registers the packed stream fields, derives line/frame
// boundary pulses and tracks raster lock. Optional checker: PXS_VGA_SPLIT_CHECK_EN.
module pxs_str_vga_split #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [22:0] VGAStr,
    input  logic        err_clr,
    output logic        HSync,
    output logic        VSync,
    output logic        ActiveVideo,
    output logic [9:0]  XCoord,
    output logic [9:0]  YCoord,
    output logic        sol,
    output logic        eol,
    output logic        sof,
    output logic        eof,
    output logic        locked,
    output logic [15:0] frame_cnt,
    output logic        err
);

    // Stream field layout (matches the Pxs.vh HS/VS/Active/XC/YC macros)
    localparam int HS_BIT  = 22;
    localparam int VS_BIT  = 21;
    localparam int ACT_BIT = 20;
    localparam int XC_LSB  = 10;
    localparam int YC_LSB  = 0;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        in_hs_s;
    logic        in_vs_s;
    logic        in_act_s;
    logic [9:0]  in_x_s;
    logic [9:0]  in_y_s;
    logic        sol_s;
    logic        eol_s;
    logic        sof_s;
    logic        eof_s;
    logic        cont_err_s;
    logic        cnt_inc_s;
    logic [15:0] frame_cnt_r;

    // Field extraction and boundary decode on the incoming pixel
    always_comb begin
        in_hs_s  = VGAStr[HS_BIT];
        in_vs_s  = VGAStr[VS_BIT];
        in_act_s = VGAStr[ACT_BIT];
        in_x_s   = VGAStr[XC_LSB +: 10];
        in_y_s   = VGAStr[YC_LSB +: 10];
        sol_s    = in_act_s && (in_x_s == 10'd0);
        eol_s    = in_act_s && (in_x_s == X_LAST);
        sof_s    = sol_s && (in_y_s == 10'd0);
        eof_s    = eol_s && (in_y_s == Y_LAST);
    end

`ifdef PXS_VGA_SPLIT_CHECK_EN
    logic       prev_act_r;
    logic [9:0] prev_x_r;
    logic [9:0] prev_y_r;
    logic [9:0] last_line_y_r;
    logic       after_eof_r;
    logic       err_r;
    logic [9:0] nxt_x_s;
    logic [9:0] nxt_line_y_s;

    // Continuity check: only active pixels seen while locked are judged
    always_comb begin
        nxt_x_s      = prev_x_r + 10'd1;
        nxt_line_y_s = after_eof_r ? 10'd0 : (last_line_y_r + 10'd1);
        cont_err_s   = 1'b0;
        if ((state_r == ST_LOCKED) && in_act_s) begin
            if (prev_act_r) begin
                cont_err_s = (in_x_s != nxt_x_s) || (in_y_s != prev_y_r);
            end else begin
                cont_err_s = (in_x_s != 10'd0) || (in_y_s != nxt_line_y_s);
            end
        end else begin
            cont_err_s = 1'b0;
        end
    end

    // Scan history; after_eof marks that the next line must restart at Y=0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_act_r    <= 1'b0;
            prev_x_r      <= 10'd0;
            prev_y_r      <= 10'd0;
            last_line_y_r <= 10'd0;
            after_eof_r   <= 1'b1;
        end else begin
            prev_act_r <= in_act_s;
            if (in_act_s) begin
                prev_x_r    <= in_x_s;
                prev_y_r    <= in_y_s;
                after_eof_r <= eof_s;
            end
            if (eol_s) begin
                last_line_y_r <= in_y_s;
            end
        end
    end

    // Sticky error flag; a fresh error beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (cont_err_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

    assign err = err_r;
`else
    logic unused_err_clr_s;

    assign unused_err_clr_s = err_clr;
    assign cont_err_s       = 1'b0;
    assign err              = 1'b0;
`endif

    // Lock state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_UNLOCKED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Lock next-state: acquire on sof, drop only on a continuity error
    always_comb begin
        state_nxt_s = state_r;
        cnt_inc_s   = 1'b0;
        case (state_r)
            ST_UNLOCKED: begin
                if (sof_s) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (cont_err_s) begin
                    state_nxt_s = ST_UNLOCKED;
                end else begin
                    state_nxt_s = ST_LOCKED;
                    cnt_inc_s   = eof_s;
                end
            end
            default: begin
                state_nxt_s = ST_UNLOCKED;
            end
        endcase
    end

    // Output pipeline stage: one clock from VGAStr to every output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            HSync       <= 1'b0;
            VSync       <= 1'b0;
            ActiveVideo <= 1'b0;
            XCoord      <= 10'd0;
            YCoord      <= 10'd0;
            sol         <= 1'b0;
            eol         <= 1'b0;
            sof         <= 1'b0;
            eof         <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            HSync       <= in_hs_s;
            VSync       <= in_vs_s;
            ActiveVideo <= in_act_s;
            XCoord      <= in_x_s;
            YCoord      <= in_y_s;
            sol         <= sol_s;
            eol         <= eol_s;
            sof         <= sof_s;
            eof         <= eof_s;
            if (cnt_inc_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    assign locked    = (state_r == ST_LOCKED);
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_pxs_str_vga_split.sv
// Randomised raster bench for pxs_str_vga_split against a pixel-expectation model.
module tb_pxs_str_vga_split;

    localparam int H      = 16;
    localparam int V      = 8;
    localparam int HB     = 4;
    localparam int VB     = 2;
    localparam int SKIP_X = 5;
`ifdef PXS_VGA_SPLIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [22:0] vga = 23'd0;
    logic        err_clr = 1'b0;
    logic        hsync, vsync, active_video, sol, eol, sof, eof, locked, err;
    logic [9:0]  xcoord, ycoord;
    logic [15:0] frame_cnt;

    pxs_str_vga_split #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst_n(rst_n), .VGAStr(vga), .err_clr(err_clr),
        .HSync(hsync), .VSync(vsync), .ActiveVideo(active_video),
        .XCoord(xcoord), .YCoord(ycoord),
        .sol(sol), .eol(eol), .sof(sof), .eof(eof),
        .locked(locked), .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: expected next active pixel is (x+1,y) right after an active one,
    // otherwise (0, last completed line + 1), or (0,0) once a frame has ended.
    bit          m_lock, m_err, m_pact, m_aeof;
    int          m_px, m_py, m_last;
    logic [15:0] m_fc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step(input logic [22:0] w, input logic clr, input logic rst);
        logic [44:0] e;
        logic [44:0] g;
        bit act, sl, el, sf, ef, cerr;
        int x, y;
        act = w[20];
        x   = int'(w[19:10]);
        y   = int'(w[9:0]);
        sl  = act && (x == 0);
        el  = act && (x == H - 1);
        sf  = sl && (y == 0);
        ef  = el && (y == V - 1);
        vga = w; err_clr = clr; rst_n = rst;
        if (!rst) begin
            m_lock = 0; m_err = 0; m_pact = 0; m_aeof = 1;
            m_px = 0; m_py = 0; m_last = 0; m_fc = 16'd0;
            e = 45'd0;
        end else begin
            cerr = 0;
            if (CHK && m_lock && act) begin
                if (m_pact) cerr = (x != (m_px + 1) % 1024) || (y != m_py);
                else        cerr = (x != 0) || (y != (m_aeof ? 0 : (m_last + 1) % 1024));
            end
            if (m_lock && !cerr && ef) m_fc = m_fc + 16'd1;
            m_lock = m_lock ? !cerr : sf;
            m_err  = cerr || (m_err && !clr);
            if (act) begin m_px = x; m_py = y; m_aeof = ef; end
            if (el) m_last = y;
            m_pact = act;
            e = {w[22], w[21], w[20], w[19:10], w[9:0], sl, el, sf, ef, m_lock, m_err, m_fc};
        end
        @(posedge clk);
        #1;
        g = {hsync, vsync, active_video, xcoord, ycoord, sol, eol, sof, eof, locked, err, frame_cnt};
        chk("outs", 64'(g), 64'(e));
    endtask

    task automatic blank(input int n, input logic clr);
        for (int i = 0; i < n; i++)
            step({$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0,
                  10'($urandom), 10'($urandom)}, clr, 1'b1);
    endtask

    // One raster frame; optional X skip on line skip_y, reset at (rst_x,rst_y), random corruption
    task automatic frame(input int skip_y, input bit clr_skip, input int rst_y, input int rst_x,
                         input bit noisy);
        bit hp, vp, act, hs, vs, clr, rst;
        logic [9:0] xc, yc;
        hp = $urandom_range(0, 1) == 1;
        vp = $urandom_range(0, 1) == 1;
        for (int y = 0; y < V + VB; y++) begin
            for (int x = 0; x < H + HB; x++) begin
                act = (y < V) && (x < H);
                hs  = hp ^ ((x >= H + 1) && (x < H + 3));
                vs  = vp ^ (y == V);
                xc  = act ? 10'(x) : 10'($urandom);
                yc  = act ? 10'(y) : 10'($urandom);
                if (act && y == skip_y && x >= SKIP_X) xc = 10'(x + 1);
                if (act && noisy && $urandom_range(0, 199) == 0) xc = 10'($urandom);
                clr = clr_skip && act && (y == skip_y) && (x == SKIP_X);
                rst = !((y == rst_y) && (x == rst_x));
                step({hs, vs, act, xc, yc}, clr, rst);
                if (act && y == skip_y && x == SKIP_X) begin
                    chk("skip_err", 64'(err), 64'(CHK));
                    chk("skip_lock", 64'(locked), 64'(!CHK));
                end
                if (!noisy && rst_y < 0 && y == 0 && x == 0) begin
                    chk("sof_pulse", 64'(sof), 64'd1);
                    chk("sof_lock", 64'(locked), 64'd1);
                end
            end
        end
    endtask

    initial begin
        step(23'd0, 1'b0, 1'b0);
        step(23'h7FFFFF, 1'b1, 1'b0);
        chk("rst_lock", 64'(locked), 64'd0);
        chk("rst_cnt", 64'(frame_cnt), 64'd0);
        blank(30, 1'b0);
        chk("idle_lock", 64'(locked), 64'd0);

        for (int f = 0; f < 3; f++) frame(-1, 1'b0, -1, -1, 1'b0);
        chk("frames3", 64'(frame_cnt), 64'd3);
        chk("frames3_err", 64'(err), 64'd0);
        chk("frames3_lock", 64'(locked), 64'd1);

        frame(3, 1'b0, -1, -1, 1'b0);
        chk("fault_cnt", 64'(frame_cnt), CHK ? 64'd3 : 64'd4);
        frame(-1, 1'b0, -1, -1, 1'b0);
        chk("relock_cnt", 64'(frame_cnt), CHK ? 64'd4 : 64'd5);
        blank(1, 1'b1);
        chk("clr_err", 64'(err), 64'd0);
        frame(5, 1'b1, -1, -1, 1'b0);
        blank(3, 1'b0);
        chk("clr_lost", 64'(err), 64'(CHK));
        blank(1, 1'b1);
        chk("clr_alone", 64'(err), 64'd0);

        frame(-1, 1'b0, 4, 8, 1'b0);
        chk("rst_hold_lock", 64'(locked), 64'd0);
        chk("rst_hold_cnt", 64'(frame_cnt), 64'd0);
        frame(-1, 1'b0, -1, -1, 1'b0);
        chk("after_rst_cnt", 64'(frame_cnt), 64'd1);

        for (int f = 0; f < 4; f++) frame(-1, 1'b0, -1, -1, 1'b1);
        frame(-1, 1'b0, -1, -1, 1'b0);

        force dut.frame_cnt_r = 16'hFFFF;
        m_fc = 16'hFFFF;
        #10;
        release dut.frame_cnt_r;
        blank(2, 1'b0);
        chk("preload", 64'(frame_cnt), 64'hFFFF);
        frame(-1, 1'b0, -1, -1, 1'b0);
        chk("wrap", 64'(frame_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
